hwpe_ctrl_uloop_gen: RTL and testbench
======================================

Name: hwpe_ctrl_uloop_gen

Overview:
Parametrised nested-loop index and offset generator, successor to the fixed 6-loop/12-bit microcode loop controller. Takes per-loop range and stride from the register file and iterates a configurable number of nested loops. Emits one index vector and one linear offset per beat over a valid/ready handshake toward the streamer address logic. Sits between the control slave (start/clear) and the streamers, and reports done back to the slave.

Parameters:
NB_LOOPS, 6, number of nested loops (1..16); loop 0 is innermost.
CNT_WIDTH, 12, width of each loop range and index.
OFFS_WIDTH, 32, width of base, strides and output offset.

Ports:
clk_i  in  1  clock.
rst_i  in  1  asynchronous active-high reset.
clear_i  in  1  synchronous soft clear.
start_i  in  1  single-cycle start pulse; latches the configuration.
base_i  in  OFFS_WIDTH  starting offset.
range_i  in  NB_LOOPS*CNT_WIDTH  iteration count per loop.
stride_i  in  NB_LOOPS*OFFS_WIDTH  offset increment per loop level.
accum_loop_i  in  $clog2(NB_LOOPS)  loop level for the accum flag (optional feature).
valid_o  out  1  beat valid.
ready_i  in  1  consumer ready.
offs_o  out  OFFS_WIDTH  current offset.
idx_o  out  NB_LOOPS*CNT_WIDTH  current index vector.
last_o  out  1  current beat is the final beat.
accum_o  out  1  accumulate flag (optional feature).
busy_o  out  1  high in RUN.
done_o  out  1  single-cycle completion pulse.

Behaviour:
- Reset (async, rst_i=1): state IDLE, all outputs 0, all index, accumulator and config registers 0.
- States: IDLE, RUN, DONE.
- IDLE + start_i:
  - latch range/stride/base; a range of 0 is stored as 1.
  - idx[all]=0, acc[all]=base_i.
  - next cycle: RUN with valid_o=1.
  - start-to-first-valid latency is 1 cycle.
- RUN:
  - valid_o=1, busy_o=1, offs_o=acc[0], idx_o=idx.
  - Outputs are registered and held stable while ready_i=0.
  - No combinational path from ready_i to valid_o.
- Beat on valid_o & ready_i:
  - l = lowest level with idx[l] != range[l]-1.
  - idx[l]++, acc[l] += stride[l].
  - For k<l: idx[k]=0, acc[k]=acc[l]+stride[l].
  - One beat per cycle sustained under continuous ready_i.
- last_o: 1 when every idx[k]==range[k]-1.
  - A handshake with last_o=1 moves to DONE.
  - No index update on that beat.
- DONE: lasts 1 cycle with done_o=1, valid_o=0, busy_o=0, then IDLE.
- Beat count: exactly the product of all ranges.
- Arithmetic: offsets wrap modulo 2^OFFS_WIDTH. Strides are unsigned; negative steps use two's complement.
- start_i in RUN or DONE: ignored.
  - Config inputs are sampled only at start.
  - Config changes mid-run have no effect.
- clear_i: any state returns to IDLE next cycle, all outputs 0.
  - clear_i has priority over start_i and over a handshake in the same cycle.
- rst_i mid-run: immediate IDLE, no done_o.

Optional Feature:
HWPE_CTRL_ULOOP_ACCUM_EN
- Defined: accum_o=valid_o & (idx[k]==range[k]-1 for all k<=accum_loop_i).
  - accum_loop_i is latched at start.
  - Marks the last beat of each accumulation group.
- Undefined: accum_o tied 0, accum_loop_i unused, no latch register.

Test Plan:
- NB_LOOPS=3, range={2,3,4} (loop0..2), stride={1,10,100}, base=0x1000, ready_i=1 → 24 beats.
  - offs sequence starts 0x1000,0x1001,0x100A,0x100B,0x1014,…
  - last beat offs=0x1000+1+20+300=0x1141 with last_o=1.
  - done_o pulses exactly 1 cycle after the last handshake.
- Same config, ready_i random 50% → identical offs/idx sequence, and outputs stable across every stall cycle.
- range={0,1,1}, base=5 → exactly one beat, offs=5, last_o=1, then done_o.
- stride0=0xFFFFFFFF, range0=3, base=1 → offs 1,0,0xFFFFFFFF (wraparound).
- clear_i asserted during beat 7 with ready_i=1 → no handshake counted, IDLE next cycle, valid_o=0, no done_o.
  - A subsequent start restarts from base.
- With HWPE_CTRL_ULOOP_ACCUM_EN, range={2,3,4}, accum_loop_i=1 → accum_o high on beats 6,12,18,24 only; without the macro, accum_o is constantly 0.

Source files
------------

// File: rtl/hwpe_ctrl_uloop_gen_if.sv
// Beat stream from the loop generator toward the streamer address logic.
// Valid/ready handshake carrying the linear offset, the index vector and the last/accum flags.
interface hwpe_ctrl_uloop_gen_if #(
  parameter int unsigned NB_LOOPS   = 6,
  parameter int unsigned CNT_WIDTH  = 12,
  parameter int unsigned OFFS_WIDTH = 32
);
  logic                          valid;
  logic                          ready;
  logic [OFFS_WIDTH-1:0]         offs;
  logic [NB_LOOPS*CNT_WIDTH-1:0] idx;
  logic                          last;
  logic                          accum;

  modport master (output valid, offs, idx, last, accum, input ready);
  modport slave  (input valid, offs, idx, last, accum, output ready);
endinterface

// File: rtl/hwpe_ctrl_uloop_gen.sv
// Parametrised nested-loop index/offset generator; loop 0 is innermost.
// Optional accumulate flag enabled by defining HWPE_CTRL_ULOOP_ACCUM_EN.
module hwpe_ctrl_uloop_gen #(
  parameter int unsigned NB_LOOPS   = 6,
  parameter int unsigned CNT_WIDTH  = 12,
  parameter int unsigned OFFS_WIDTH = 32,
  localparam int unsigned AL_WIDTH  = (NB_LOOPS > 1) ? $clog2(NB_LOOPS) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  input  logic                           start_i,
  input  logic [OFFS_WIDTH-1:0]          base_i,
  input  logic [NB_LOOPS*CNT_WIDTH-1:0]  range_i,
  input  logic [NB_LOOPS*OFFS_WIDTH-1:0] stride_i,
  input  logic [AL_WIDTH-1:0]            accum_loop_i,
  hwpe_ctrl_uloop_gen_if.master          uloop,
  output logic                           busy_o,
  output logic                           done_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  range_q  [NB_LOOPS];
  logic [CNT_WIDTH-1:0]  range_d  [NB_LOOPS];
  logic [OFFS_WIDTH-1:0] stride_q [NB_LOOPS];
  logic [OFFS_WIDTH-1:0] stride_d [NB_LOOPS];
  logic [CNT_WIDTH-1:0]  idx_q    [NB_LOOPS];
  logic [CNT_WIDTH-1:0]  idx_d    [NB_LOOPS];
  logic [OFFS_WIDTH-1:0] acc_q    [NB_LOOPS];
  logic [OFFS_WIDTH-1:0] acc_d    [NB_LOOPS];

  logic [NB_LOOPS-1:0]   at_max;
  logic                  all_max;
  int unsigned           lvl;
  logic [OFFS_WIDTH-1:0] step;
  logic                  run;
  logic                  accum_flag;

  // Lowest loop level that still has iterations left, and its next offset.
  always_comb begin
    at_max  = '0;
    all_max = 1'b1;
    lvl     = 0;
    step    = '0;
    for (int unsigned k = 0; k < NB_LOOPS; k++) begin
      at_max[k] = (idx_q[k] == range_q[k] - CNT_WIDTH'(1));
    end
    for (int unsigned k = NB_LOOPS; k > 0; k--) begin
      if (!at_max[k-1]) begin
        all_max = 1'b0;
        lvl     = k - 1;
        step    = acc_q[k-1] + stride_q[k-1];
      end
    end
  end

`ifdef HWPE_CTRL_ULOOP_ACCUM_EN
  logic [AL_WIDTH-1:0] accum_loop_q, accum_loop_d;

  always_comb begin
    accum_flag = 1'b1;
    for (int unsigned k = 0; k < NB_LOOPS; k++) begin
      if (k <= 32'(accum_loop_q) && !at_max[k]) accum_flag = 1'b0;
    end
  end

  always_comb begin
    accum_loop_d = accum_loop_q;
    if (!clear_i && state_q == IDLE && start_i) accum_loop_d = accum_loop_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) accum_loop_q <= '0;
    else       accum_loop_q <= accum_loop_d;
  end
`else
  logic unused_accum_loop;
  assign unused_accum_loop = ^accum_loop_i;
  assign accum_flag        = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    range_d  = range_q;
    stride_d = stride_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    if (clear_i) begin
      state_d = IDLE;
      for (int unsigned k = 0; k < NB_LOOPS; k++) begin
        idx_d[k] = '0;
        acc_d[k] = '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = RUN;
            for (int unsigned k = 0; k < NB_LOOPS; k++) begin
              range_d[k]  = (range_i[k*CNT_WIDTH +: CNT_WIDTH] == '0) ? CNT_WIDTH'(1)
                                                                       : range_i[k*CNT_WIDTH +: CNT_WIDTH];
              stride_d[k] = stride_i[k*OFFS_WIDTH +: OFFS_WIDTH];
              idx_d[k]    = '0;
              acc_d[k]    = base_i;
            end
          end
        end
        RUN: begin
          if (uloop.ready) begin
            if (all_max) begin
              state_d = DONE;
            end else begin
              // Lower levels restart at the freshly advanced offset of level lvl.
              for (int unsigned k = 0; k < NB_LOOPS; k++) begin
                if (k == lvl) begin
                  idx_d[k] = idx_q[k] + CNT_WIDTH'(1);
                  acc_d[k] = step;
                end else if (k < lvl) begin
                  idx_d[k] = '0;
                  acc_d[k] = step;
                end
              end
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      for (int unsigned k = 0; k < NB_LOOPS; k++) begin
        range_q[k]  <= '0;
        stride_q[k] <= '0;
        idx_q[k]    <= '0;
        acc_q[k]    <= '0;
      end
    end else begin
      state_q  <= state_d;
      range_q  <= range_d;
      stride_q <= stride_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
    end
  end

  // Outputs derive only from registered state, so ready never reaches valid.
  always_comb begin
    run         = (state_q == RUN);
    uloop.valid = run;
    uloop.last  = run & all_max;
    uloop.accum = run & accum_flag;
    uloop.offs  = run ? acc_q[0] : '0;
    uloop.idx   = '0;
    for (int unsigned k = 0; k < NB_LOOPS; k++) begin
      uloop.idx[k*CNT_WIDTH +: CNT_WIDTH] = run ? idx_q[k] : '0;
    end
    busy_o = run;
    done_o = (state_q == DONE);
  end

endmodule

// File: tb/tb_hwpe_ctrl_uloop_gen.sv
// Randomized self-checking bench for hwpe_ctrl_uloop_gen (3 loops) against a
// mixed-radix reference model: beat n has idx = digits of n, offs = base + sum(idx*stride).
module tb_hwpe_ctrl_uloop_gen;
  localparam int unsigned NL = 3;
  localparam int unsigned CW = 12;
  localparam int unsigned OW = 32;
  localparam int unsigned NO_CLEAR = 32'hFFFF;

  logic           clk = 1'b0;
  logic           rst, clear, start;
  logic [OW-1:0]  base;
  logic [NL*CW-1:0] range_v;
  logic [NL*OW-1:0] stride_v;
  logic [1:0]     accloop;
  logic           busy, done;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  int unsigned   m_range [NL];
  logic [OW-1:0] m_stride[NL];
  logic [OW-1:0] m_base;
  int unsigned   m_al;
  logic [OW-1:0] obs_offs[$];

  hwpe_ctrl_uloop_gen_if #(.NB_LOOPS(NL), .CNT_WIDTH(CW), .OFFS_WIDTH(OW)) uloop_if ();

  hwpe_ctrl_uloop_gen #(.NB_LOOPS(NL), .CNT_WIDTH(CW), .OFFS_WIDTH(OW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (clear),
    .start_i      (start),
    .base_i       (base),
    .range_i      (range_v),
    .stride_i     (stride_v),
    .accum_loop_i (accloop),
    .uloop        (uloop_if.master),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic int unsigned m_total();
    int unsigned t = 1;
    for (int k = 0; k < NL; k++) t *= m_range[k];
    return t;
  endfunction

  function automatic logic [NL*CW-1:0] m_idx(input int unsigned n);
    logic [NL*CW-1:0] v = '0;
    int unsigned r = n;
    for (int k = 0; k < NL; k++) begin
      v[k*CW +: CW] = CW'(r % m_range[k]);
      r = r / m_range[k];
    end
    return v;
  endfunction

  function automatic logic [OW-1:0] m_offs(input int unsigned n);
    logic [OW-1:0] o = m_base;
    int unsigned r = n;
    for (int k = 0; k < NL; k++) begin
      o = o + OW'(r % m_range[k]) * m_stride[k];
      r = r / m_range[k];
    end
    return o;
  endfunction

  function automatic logic m_accum(input int unsigned n);
`ifdef HWPE_CTRL_ULOOP_ACCUM_EN
    int unsigned grp = 1;
    for (int k = 0; k < NL; k++) if (k <= int'(m_al)) grp *= m_range[k];
    return ((n + 1) % grp) == 0;
`else
    return 1'b0 & n[0];
`endif
  endfunction

  task automatic run_cfg(input logic [OW-1:0] b, input int unsigned r0, input int unsigned r1,
                         input int unsigned r2, input logic [OW-1:0] s0, input logic [OW-1:0] s1,
                         input logic [OW-1:0] s2, input int unsigned al, input bit rnd,
                         input int unsigned clear_at);
    int unsigned n = 0;
    int unsigned cyc = 0;
    int unsigned tot;
    bit hs;
    m_base = b; m_al = al;
    m_range[0] = (r0 == 0) ? 1 : r0;
    m_range[1] = (r1 == 0) ? 1 : r1;
    m_range[2] = (r2 == 0) ? 1 : r2;
    m_stride[0] = s0; m_stride[1] = s1; m_stride[2] = s2;
    tot = m_total();
    obs_offs.delete();
    @(negedge clk);
    base = b; range_v = {CW'(r2), CW'(r1), CW'(r0)}; stride_v = {s2, s1, s0};
    accloop = 2'(al); start = 1'b1; uloop_if.ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    base = $urandom; range_v = {$urandom, $urandom}; stride_v = {$urandom, $urandom, $urandom};
    accloop = 2'($urandom_range(0, 2));
    while (n < tot && cyc < 2000) begin
      check_val("valid", uloop_if.valid, 1);
      check_val("busy", busy, 1);
      check_val("offs", uloop_if.offs, m_offs(n));
      check_val("idx", uloop_if.idx, m_idx(n));
      check_val("last", uloop_if.last, n == tot - 1);
      check_val("accum", uloop_if.accum, m_accum(n));
      if (n == clear_at) begin
        uloop_if.ready = 1'b1; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; uloop_if.ready = 1'b0;
        check_val("clr_valid", uloop_if.valid, 0);
        check_val("clr_busy", busy, 0);
        check_val("clr_offs", uloop_if.offs, 0);
        check_val("clr_done", done, 0);
        @(negedge clk);
        check_val("clr_done2", done, 0);
        check_val("clr_valid2", uloop_if.valid, 0);
        return;
      end
      uloop_if.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = rnd && (cyc == 4);
      hs = uloop_if.ready && uloop_if.valid;
      if (hs) obs_offs.push_back(uloop_if.offs);
      @(negedge clk);
      if (hs) n++;
      cyc++;
    end
    start = 1'b0;
    check_val("beats_done", n, tot);
    check_val("done_pulse", done, 1);
    check_val("done_valid", uloop_if.valid, 0);
    check_val("done_busy", busy, 0);
    uloop_if.ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_val("done_once", done, 0);
    check_val("idle_valid", uloop_if.valid, 0);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; start = 1'b0; base = '0; range_v = '0; stride_v = '0;
    accloop = '0; uloop_if.ready = 1'b0;
    #1;
    check_val("rst_valid", uloop_if.valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_offs", uloop_if.offs, 0);
    check_val("rst_idx", uloop_if.idx, 0);
    check_val("rst_last", uloop_if.last, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_cfg(32'h1000, 2, 3, 4, 1, 10, 100, 1, 1'b0, NO_CLEAR);
    check_val("n_beats", obs_offs.size(), 24);
    check_val("offs0", obs_offs[0], 32'h1000);
    check_val("offs1", obs_offs[1], 32'h1001);
    check_val("offs2", obs_offs[2], 32'h100A);
    check_val("offs3", obs_offs[3], 32'h100B);
    check_val("offs4", obs_offs[4], 32'h1014);
    check_val("offs_last", obs_offs[23], 32'h1141);

    run_cfg(32'h1000, 2, 3, 4, 1, 10, 100, 1, 1'b1, NO_CLEAR);
    check_val("stall_beats", obs_offs.size(), 24);

    run_cfg(5, 0, 1, 1, 7, 7, 7, 0, 1'b0, NO_CLEAR);
    check_val("single_beats", obs_offs.size(), 1);
    check_val("single_offs", obs_offs[0], 5);

    run_cfg(1, 3, 1, 1, 32'hFFFFFFFF, 0, 0, 0, 1'b0, NO_CLEAR);
    check_val("wrap_offs2", obs_offs[2], 32'hFFFFFFFF);

    run_cfg(32'h1000, 2, 3, 4, 1, 10, 100, 1, 1'b0, 6);
    run_cfg(32'h1000, 2, 3, 4, 1, 10, 100, 2, 1'b1, NO_CLEAR);

    repeat (6) begin
      run_cfg($urandom, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom, $urandom, $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)), NO_CLEAR);
    end

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    base = 32'h40; range_v = {12'd4, 12'd4, 12'd4}; stride_v = {32'd1, 32'd1, 32'd1};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; uloop_if.ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("arst_valid", uloop_if.valid, 0);
    check_val("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("arst_done", done, 0);
    check_val("arst_idle", uloop_if.valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
